// File: rtl/axi_write_slave.sv
// ---------------------------------------------------------------------------
// axi_write_slave
//
// AXI write-channel slave that turns write bursts into single-cycle SRAM
// write strobes. One transaction is in flight at a time: the address phase
// is taken in IDLE, data beats are streamed straight to the SRAM in WDATA,
// and the write response is held in BRESP until the master takes it.
//
// Ports
//   ACLK, ARESETn               clock, asynchronous active-low reset
//   AWID/AWADDR/AWLEN/AWSIZE/
//   AWBURST/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WLAST/
//   WVALID/WREADY               write data channel
//   BID/BRESP/BVALID/BREADY     write response channel
//   sram_CEB, sram_WEB          active-low chip / write enable
//   sram_BWEB                   active-low per-bit write mask
//   sram_A, sram_DI             SRAM word address and write data
// ---------------------------------------------------------------------------
module axi_write_slave #(
    parameter int AXI_IDS_BITS   = 8,
    parameter int SRAM_ADDR_BITS = 14
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [AXI_IDS_BITS-1:0]   AWID,
    input  logic [31:0]               AWADDR,
    input  logic [3:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [31:0]               WDATA,
    input  logic [3:0]                WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [AXI_IDS_BITS-1:0]   BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic                      sram_CEB,
    output logic                      sram_WEB,
    output logic [31:0]               sram_BWEB,
    output logic [SRAM_ADDR_BITS-1:0] sram_A,
    output logic [31:0]               sram_DI
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_BRESP = 2'd2;

    localparam logic [SRAM_ADDR_BITS-1:0] PTR_ONE = {{(SRAM_ADDR_BITS-1){1'b0}}, 1'b1};

    logic [1:0]                state;
    logic [AXI_IDS_BITS-1:0]   id_q;
    logic [SRAM_ADDR_BITS-1:0] ptr_q;
    logic [SRAM_ADDR_BITS-1:0] ptr_nxt;
    logic [SRAM_ADDR_BITS-1:0] wrap_mask;
    logic [3:0]                len_q;
    logic [3:0]                beat_cnt;
    logic [1:0]                burst_q;
    logic                      size_ok_q;
    logic                      err_q;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      last_beat;
    logic                      beat_err;
    logic                      sram_wr;
    logic                      unused_addr_bits;

    // Only the word-address slice of AWADDR is meaningful to the SRAM.
    assign unused_addr_bits = ^{AWADDR[31:SRAM_ADDR_BITS+2], AWADDR[1:0]};

    // Handshake readiness is purely a function of the state, so reset
    // immediately presents AWREADY=1 and drops WREADY/BVALID.
    assign AWREADY   = (state == S_IDLE);
    assign WREADY    = (state == S_WDATA);
    assign BVALID    = (state == S_BRESP);

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign last_beat = (beat_cnt == len_q);
    // WLAST must agree with the beat count; the count still ends the burst.
    assign beat_err  = (WLAST != last_beat);
    // Bursts with an unsupported size still handshake but never touch SRAM.
    assign sram_wr   = w_hs && size_ok_q;

    // WRAP bursts only advance the low bits selected by the burst length
    // (lengths 2/4/8/16 give contiguous masks), the upper bits stay put.
    assign wrap_mask = {{(SRAM_ADDR_BITS-4){1'b0}}, len_q};

    always_comb begin
        ptr_nxt = ptr_q;
        case (burst_q)
            2'b00:   ptr_nxt = ptr_q;
            2'b10:   ptr_nxt = (ptr_q & ~wrap_mask) | ((ptr_q + PTR_ONE) & wrap_mask);
            default: ptr_nxt = ptr_q + PTR_ONE;
        endcase
    end

    // SRAM port is driven combinationally in the same cycle as the W
    // handshake; address and data are zeroed when idle so reset is clean.
    always_comb begin
        sram_CEB  = ~sram_wr;
        sram_WEB  = ~sram_wr;
        sram_A    = sram_wr ? ptr_q : '0;
        sram_DI   = sram_wr ? WDATA : '0;
        sram_BWEB = '1;
        if (sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                sram_BWEB[8*i +: 8] = {8{~WSTRB[i]}};
            end
        end
    end

    // Transaction FSM. BID/BRESP are loaded on the final beat so they are
    // stable for the whole response and hold afterwards.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            id_q      <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            size_ok_q <= 1'b0;
            err_q     <= 1'b0;
            beat_cnt  <= '0;
            BID       <= '0;
            BRESP     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (aw_hs) begin
                        id_q      <= AWID;
                        ptr_q     <= AWADDR[SRAM_ADDR_BITS+1:2];
                        len_q     <= AWLEN;
                        burst_q   <= AWBURST;
                        size_ok_q <= (AWSIZE == 3'b010);
                        err_q     <= (AWSIZE != 3'b010);
                        beat_cnt  <= '0;
                        state     <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        ptr_q    <= ptr_nxt;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            BID   <= id_q;
                            BRESP <= (err_q || beat_err) ? 2'b10 : 2'b00;
                            state <= S_BRESP;
                        end
                    end
                end
                S_BRESP: begin
                    if (BREADY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_write_slave
//
// Directed bench for axi_write_slave. Inputs are driven on the falling
// edge, outputs are sampled 1ns later, and the DUT captures on the rising
// edge. Every expected value below is worked out by hand from the
// burst parameters.
// ---------------------------------------------------------------------------
module tb_axi_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        sram_CEB;
    logic        sram_WEB;
    logic [31:0] sram_BWEB;
    logic [13:0] sram_A;
    logic [31:0] sram_DI;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axi_write_slave #(.AXI_IDS_BITS(8), .SRAM_ADDR_BITS(14)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .BREADY(BREADY), .sram_CEB(sram_CEB), .sram_WEB(sram_WEB),
        .sram_BWEB(sram_BWEB), .sram_A(sram_A), .sram_DI(sram_DI)
    );

    always #5 ACLK = ~ACLK;

    // One full address handshake: present on a falling edge, drop after
    // the rising edge that accepts it.
    task automatic aw_handshake(input logic [7:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    endtask

    task automatic test_reset();
        logic [92:0] act, exp;
        #2;
        act = {AWREADY, WREADY, BVALID, BID, BRESP, sram_CEB, sram_WEB, sram_BWEB, sram_A, sram_DI};
        exp = {1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0};
        total_cnt++;
        if (act !== exp) $display("[TB] FAIL reset_outputs: got %h expected %h", act, exp);
        else pass_cnt++;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        total_cnt++;
        if ({AWREADY, WREADY, BVALID, sram_CEB} !== 4'b1001)
            $display("[TB] FAIL post_reset_idle: got %b expected 1001", {AWREADY, WREADY, BVALID, sram_CEB});
        else pass_cnt++;
    endtask

    task automatic test_incr_single();
        logic [81:0] act, exp;
        logic [12:0] bact, bexp;
        aw_handshake(8'h3C, 32'h10, 4'd0, 3'd2, 2'b01);
        drive_w(32'hA5A5_A5A5, 4'hF, 1'b1);
        #1;
        act = {AWREADY, WREADY, sram_CEB, sram_WEB, sram_A, sram_BWEB, sram_DI};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 14'd4, 32'h0000_0000, 32'hA5A5_A5A5};
        total_cnt++;
        if (act !== exp) $display("[TB] FAIL single_write: got %h expected %h", act, exp);
        else pass_cnt++;
        @(negedge ACLK);
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP, AWREADY, WREADY};
        bexp = {1'b1, 8'h3C, 2'b00, 1'b0, 1'b0};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL single_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP, AWREADY, WREADY};
        bexp = {1'b0, 8'h3C, 2'b00, 1'b1, 1'b0};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL single_b_hold: got %h expected %h", bact, bexp);
        else pass_cnt++;
    endtask

    task automatic test_incr_burst();
        logic [13:0] exp_a [4];
        logic [80:0] act, exp;
        logic [10:0] bact, bexp;
        exp_a = '{14'd4, 14'd5, 14'd6, 14'd7};
        aw_handshake(8'h11, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive_w(32'h1000_0000 + i, 4'b0101, i == 3);
            #1;
            act = {WREADY, sram_CEB, sram_WEB, sram_A, sram_BWEB, sram_DI};
            exp = {1'b1, 1'b0, 1'b0, exp_a[i], 32'hFF00_FF00, 32'h1000_0000 + i};
            total_cnt++;
            if (act !== exp) $display("[TB] FAIL incr4_beat%0d: got %h expected %h", i, act, exp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h11, 2'b00};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL incr4_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_wrap();
        logic [13:0] exp_a [4];
        logic [80:0] act, exp;
        logic [10:0] bact, bexp;
        exp_a = '{14'd6, 14'd7, 14'd4, 14'd5};
        aw_handshake(8'h22, 32'h18, 4'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            drive_w(32'h2000_0000 + i, 4'hF, i == 3);
            #1;
            act = {WREADY, sram_CEB, sram_WEB, sram_A, sram_BWEB, sram_DI};
            exp = {1'b1, 1'b0, 1'b0, exp_a[i], 32'h0000_0000, 32'h2000_0000 + i};
            total_cnt++;
            if (act !== exp) $display("[TB] FAIL wrap_beat%0d: got %h expected %h", i, act, exp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h22, 2'b00};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL wrap_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_fixed_zero_strb();
        logic [3:0]  strb [2];
        logic [31:0] exp_bweb [2];
        logic [80:0] act, exp;
        logic [10:0] bact, bexp;
        strb     = '{4'hF, 4'h0};
        exp_bweb = '{32'h0000_0000, 32'hFFFF_FFFF};
        aw_handshake(8'h33, 32'h20, 4'd1, 3'd2, 2'b00);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'h3000_0000 + i, strb[i], i == 1);
            #1;
            act = {WREADY, sram_CEB, sram_WEB, sram_A, sram_BWEB, sram_DI};
            exp = {1'b1, 1'b0, 1'b0, 14'd8, exp_bweb[i], 32'h3000_0000 + i};
            total_cnt++;
            if (act !== exp) $display("[TB] FAIL fixed_beat%0d: got %h expected %h", i, act, exp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h33, 2'b00};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL fixed_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_wlast_error();
        logic [13:0] exp_a [3];
        logic        last [3];
        logic [16:0] act, exp;
        logic [10:0] bact, bexp;
        exp_a = '{14'd16, 14'd17, 14'd18};
        last  = '{1'b0, 1'b1, 1'b1};
        aw_handshake(8'h44, 32'h40, 4'd2, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++) begin
            drive_w(32'h4000_0000 + i, 4'hF, last[i]);
            #1;
            act = {WREADY, sram_CEB, sram_WEB, sram_A};
            exp = {1'b1, 1'b0, 1'b0, exp_a[i]};
            total_cnt++;
            if (act !== exp) $display("[TB] FAIL wlast_beat%0d: got %h expected %h", i, act, exp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h44, 2'b10};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL wlast_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_bad_size();
        logic [34:0] act, exp;
        logic [10:0] bact, bexp;
        aw_handshake(8'h55, 32'h0, 4'd1, 3'd0, 2'b01);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'h5000_0000 + i, 4'hF, i == 1);
            #1;
            act = {WREADY, sram_CEB, sram_WEB, sram_BWEB};
            exp = {1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
            total_cnt++;
            if (act !== exp) $display("[TB] FAIL badsize_beat%0d: got %h expected %h", i, act, exp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h55, 2'b10};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL badsize_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_bready_stall();
        logic [11:0] bact, bexp;
        aw_handshake(8'h66, 32'h8, 4'd0, 3'd2, 2'b01);
        drive_w(32'h6666_6666, 4'hF, 1'b1);
        #1;
        total_cnt++;
        if ({sram_CEB, sram_A} !== {1'b0, 14'd2})
            $display("[TB] FAIL stall_write: got %h expected %h", {sram_CEB, sram_A}, {1'b0, 14'd2});
        else pass_cnt++;
        @(negedge ACLK);
        WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            bact = {BVALID, BID, BRESP, AWREADY};
            bexp = {1'b1, 8'h66, 2'b00, 1'b0};
            total_cnt++;
            if (bact !== bexp) $display("[TB] FAIL stall_cycle%0d: got %h expected %h", c, bact, bexp);
            else pass_cnt++;
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        total_cnt++;
        if ({BVALID, AWREADY} !== 2'b01)
            $display("[TB] FAIL stall_release: got %b expected 01", {BVALID, AWREADY});
        else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        logic [47:0] act, exp;
        logic [10:0] bact, bexp;
        @(negedge ACLK);
        drive_w(32'hCAFE_F00D, 4'hF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if ({WREADY, sram_CEB} !== 2'b01)
                $display("[TB] FAIL early_w_cycle%0d: got %b expected 01", c, {WREADY, sram_CEB});
            else pass_cnt++;
            @(negedge ACLK);
        end
        aw_handshake(8'h77, 32'h30, 4'd0, 3'd2, 2'b01);
        #1;
        act = {WREADY, sram_CEB, sram_A, sram_DI};
        exp = {1'b1, 1'b0, 14'd12, 32'hCAFE_F00D};
        total_cnt++;
        if (act !== exp) $display("[TB] FAIL early_w_accept: got %h expected %h", act, exp);
        else pass_cnt++;
        @(negedge ACLK);
        WVALID = 1'b0;
        #1;
        bact = {BVALID, BID, BRESP};
        bexp = {1'b1, 8'h77, 2'b00};
        total_cnt++;
        if (bact !== bexp) $display("[TB] FAIL early_w_bresp: got %h expected %h", bact, bexp);
        else pass_cnt++;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [81:0] act, exp;
        aw_handshake(8'h88, 32'h50, 4'd3, 3'd2, 2'b01);
        drive_w(32'h8000_0000, 4'hF, 1'b0);
        @(negedge ACLK);
        drive_w(32'h8000_0001, 4'hF, 1'b0);
        #1;
        total_cnt++;
        if ({sram_CEB, sram_A} !== {1'b0, 14'd21})
            $display("[TB] FAIL midrst_beat1: got %h expected %h", {sram_CEB, sram_A}, {1'b0, 14'd21});
        else pass_cnt++;
        #1;
        ARESETn = 1'b0;
        #1;
        act = {sram_CEB, sram_WEB, sram_BWEB, sram_A, sram_DI, WREADY, AWREADY};
        exp = {1'b1, 1'b1, 32'hFFFF_FFFF, 14'd0, 32'h0, 1'b0, 1'b1};
        total_cnt++;
        if (act !== exp) $display("[TB] FAIL midrst_async: got %h expected %h", act, exp);
        else pass_cnt++;
        WVALID = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if ({BVALID, AWREADY, WREADY} !== 3'b010)
                $display("[TB] FAIL midrst_after%0d: got %b expected 010", c, {BVALID, AWREADY, WREADY});
            else pass_cnt++;
            @(negedge ACLK);
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        test_reset();
        test_incr_single();
        test_incr_burst();
        test_wrap();
        test_fixed_zero_strb();
        test_wlast_error();
        test_bad_size();
        test_bready_stall();
        test_w_before_aw();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_write_slave.md
AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

Interface
REQ-001 SHALL have parameters: AXI_IDS_BITS, default 8, slave-side ID width; SRAM_ADDR_BITS, default 14, SRAM word-address width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- ACLK, in, 1, single clock; all state changes on rising edge.
- ARESETn, in, 1, asynchronous active-low reset.
- AWID, in, AXI_IDS_BITS, write ID.
- AWADDR, in, 32, byte offset from slave base (base already subtracted upstream).
- AWLEN, in, 4, beats minus 1.
- AWSIZE, in, 3, beat size.
- AWBURST, in, 2, burst type.
- AWVALID, in, 1, address valid.
- AWREADY, out, 1, address accepted.
- WDATA, in, 32, write data.
- WSTRB, in, 4, byte strobes.
- WLAST, in, 1, final beat.
- WVALID, in, 1, data valid.
- WREADY, out, 1, data accepted.
- BID, out, AXI_IDS_BITS, response ID.
- BRESP, out, 2, response code.
- BVALID, out, 1, response valid.
- BREADY, in, 1, response accepted.
- sram_CEB, out, 1, chip enable, active-low.
- sram_WEB, out, 1, write enable, active-low.
- sram_BWEB, out, 32, per-bit write mask, active-low.
- sram_A, out, SRAM_ADDR_BITS, word address.
- sram_DI, out, 32, write data.

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, WDATA, BRESP; one write transaction outstanding at a time.
REQ-004 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&&AWREADY, latch AWID, AWADDR[SRAM_ADDR_BITS+1:2] as word pointer, AWLEN, AWBURST, AWSIZE; clear beat counter and error flag; go to WDATA.
REQ-005 WDATA: AWREADY=0, WREADY=1; W beats presented before the AW handshake SHALL stall (WREADY=0 in IDLE).
REQ-006 On each WVALID&&WREADY, the same cycle SHALL drive sram_CEB=0, sram_WEB=0, sram_A=word pointer, sram_DI=WDATA, sram_BWEB[8i+7:8i]=~{8{WSTRB[i]}}; otherwise sram_CEB=1, sram_WEB=1, sram_BWEB=all ones.
REQ-007 WSTRB=4'b0000 SHALL still assert sram_CEB/WEB with BWEB all ones (no byte modified).
REQ-008 Pointer update per accepted beat: FIXED (2'b00) hold; INCR (2'b01) +1 modulo 2^SRAM_ADDR_BITS; WRAP (2'b10) +1 within aligned block of AWLEN+1 words (low bits wrap, high bits hold); 2'b11 treated as INCR.
REQ-009 Beat counter (4-bit) SHALL increment per accepted beat; the beat where counter==latched AWLEN is final; next state BRESP.
REQ-010 Error flag SHALL set if WLAST=1 on a non-final beat or WLAST=0 on the final beat; beat count (AWLEN) always governs termination.
REQ-011 AWSIZE!=3'b010 SHALL set error flag and suppress all SRAM writes for that burst (CEB stays 1) while still completing W handshakes.
REQ-012 BRESP state: BVALID=1, BID=latched ID, BRESP=2'b10 (SLVERR) if error flag else 2'b00 (OKAY); values stable while BREADY=0; on BVALID&&BREADY go to IDLE.
REQ-013 Latency: BVALID asserted the cycle after the final W handshake; AWREADY reasserted the cycle after the B handshake.
REQ-014 BID/BRESP SHALL hold last values when BVALID=0.

Reset
REQ-015 ARESETn low SHALL immediately force IDLE; outputs: AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=2'b00, sram_CEB=1, sram_WEB=1, sram_BWEB=all ones, sram_A=0, sram_DI=0.
REQ-016 Reset mid-burst or mid-response SHALL abandon the transaction; no B response issued after release.

Verification
REQ-017 INCR single: AWADDR=0x10, AWLEN=0, AWSIZE=2, WDATA=0xA5A5A5A5, WSTRB=4'hF, WLAST=1 -> one SRAM write A=4, BWEB=0, next cycle BVALID=1, BRESP=00, BID=AWID.
REQ-018 INCR 4-beat, WSTRB=4'b0101 -> A=4,5,6,7; BWEB=0xFF00FF00 each beat; BRESP=00.
REQ-019 WRAP AWLEN=3 at AWADDR=0x18 -> A=6,7,4,5; BRESP=00.
REQ-020 WLAST early on beat 1 of AWLEN=2 -> 3 writes performed, BRESP=2'b10; AWSIZE=0 -> no writes, BRESP=2'b10.
REQ-021 BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0; W presented before AW -> WREADY=0 until AW accepted.
REQ-022 ARESETn pulsed low after beat 1 of 4 -> SRAM strobes deassert asynchronously, no BVALID, AWREADY=1 after release.
